// File: rtl/packer_arbiter.sv
// Merges a header codeword source and an encoder codeword source into one registered
// codeword stream for a bit packer. Define PACKER_ARB_HEADER_EN to enable the header path.
module packer_arbiter #(
    parameter int MAX_IN_WIDTH = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    hdr_valid,
    output logic                    hdr_ready,
    input  logic [MAX_IN_WIDTH-1:0] hdr_data,
    input  logic [4:0]              hdr_num_bits,
    input  logic                    hdr_last,
    input  logic                    enc_valid,
    output logic                    enc_ready,
    input  logic [MAX_IN_WIDTH-1:0] enc_data,
    input  logic [4:0]              enc_num_bits,
    input  logic                    enc_last,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [MAX_IN_WIDTH-1:0] out_data,
    output logic [4:0]              out_num_bits,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    frame_count,
    output logic                    len_err
);

`ifdef PACKER_ARB_HEADER_EN
    typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;
`else
    typedef enum logic {IDLE, BODY} state_t;
`endif

    state_t                  state;
    logic                    hdr_acc;
    logic                    enc_acc;
    logic                    cw_acc;
    logic                    cw_last;
    logic                    cw_fwd;
    logic                    cw_over;
    logic [MAX_IN_WIDTH-1:0] cw_data;
    logic [4:0]              cw_bits;
    logic [4:0]              cw_len;

    logic                    vld_p1;
    logic                    last_p1;
    logic [MAX_IN_WIDTH-1:0] data_p1;
    logic [4:0]              bits_p1;
    logic                    done_p1;
    logic [CNT_WIDTH-1:0]    cnt_p1;
    logic                    len_err_p1;

    function automatic logic [4:0] clamp_len(input logic [4:0] n);
        if (int'(n) > MAX_IN_WIDTH) return 5'(MAX_IN_WIDTH);
        return n;
    endfunction

    function automatic logic [MAX_IN_WIDTH-1:0] mask_data(input logic [MAX_IN_WIDTH-1:0] d,
                                                          input logic [4:0] len);
        logic [MAX_IN_WIDTH-1:0] m;
        for (int i = 0; i < MAX_IN_WIDTH; i++) begin
            m[i] = d[i] & (i < int'(len));
        end
        return m;
    endfunction

`ifdef PACKER_ARB_HEADER_EN
    assign hdr_ready = (state != BODY);
    assign enc_ready = (state == BODY);
    assign hdr_acc   = hdr_valid & hdr_ready;
`else
    // Without a header path the encoder owns the stream from IDLE onwards.
    logic unused_hdr;
    assign unused_hdr = ^{hdr_valid, hdr_data, hdr_num_bits, hdr_last};
    assign hdr_ready  = 1'b0;
    assign enc_ready  = 1'b1;
    assign hdr_acc    = 1'b0;
`endif

    assign enc_acc = enc_valid & enc_ready;
    assign busy    = (state != IDLE);

    always_comb begin
        cw_acc  = hdr_acc | enc_acc;
        cw_data = enc_data;
        cw_bits = enc_num_bits;
        cw_last = enc_acc & enc_last;
        if (hdr_acc) begin
            cw_data = hdr_data;
            cw_bits = hdr_num_bits;
        end
        cw_len  = clamp_len(cw_bits);
        cw_fwd  = cw_acc & (cw_bits != 5'd0);
        cw_over = cw_acc & (int'(cw_bits) > MAX_IN_WIDTH);
    end

    // Stage p1: accepted codeword registered onto the output stream
    always_ff @(posedge clk) begin
        if (areset) begin
            state      <= IDLE;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            data_p1    <= '0;
            bits_p1    <= '0;
            done_p1    <= 1'b0;
            cnt_p1     <= '0;
            len_err_p1 <= 1'b0;
        end else begin
            vld_p1  <= cw_fwd;
            last_p1 <= cw_fwd & cw_last;
            data_p1 <= cw_fwd ? mask_data(cw_data, cw_len) : '0;
            bits_p1 <= cw_fwd ? cw_len : 5'd0;
            // Zero-length last codewords still close the frame.
            done_p1 <= cw_last;
            if (cw_last) cnt_p1 <= cnt_p1 + CNT_WIDTH'(1);
            if (cw_over) len_err_p1 <= 1'b1;
`ifdef PACKER_ARB_HEADER_EN
            if (hdr_acc) state <= hdr_last ? BODY : HEADER;
            else if (enc_acc) state <= enc_last ? IDLE : BODY;
`else
            if (enc_acc) state <= enc_last ? IDLE : BODY;
`endif
        end
    end

    assign out_valid    = vld_p1;
    assign out_last     = last_p1;
    assign out_data     = data_p1;
    assign out_num_bits = bits_p1;
    assign done         = done_p1;
    assign frame_count  = cnt_p1;
    assign len_err      = len_err_p1;

endmodule

// File: tb/tb_packer_arbiter.sv
// Scoreboard bench for packer_arbiter: frame-level reference model feeds expected codewords
// and frame completions into queues that a negedge monitor drains against the DUT.
module tb_packer_arbiter;
    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          areset;
    logic          hdr_valid, hdr_ready, hdr_last;
    logic [W-1:0]  hdr_data;
    logic [4:0]    hdr_num_bits;
    logic          enc_valid, enc_ready, enc_last;
    logic [W-1:0]  enc_data;
    logic [4:0]    enc_num_bits;
    logic          out_valid, out_last;
    logic [W-1:0]  out_data;
    logic [4:0]    out_num_bits;
    logic          busy, done, len_err;
    logic [CW-1:0] frame_count;

    packer_arbiter #(.MAX_IN_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .areset(areset),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data),
        .hdr_num_bits(hdr_num_bits), .hdr_last(hdr_last),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data),
        .enc_num_bits(enc_num_bits), .enc_last(enc_last),
        .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
        .out_num_bits(out_num_bits), .busy(busy), .done(done),
        .frame_count(frame_count), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [4:0]   n;
        bit           l;
        time          due;
    } item_t;

    item_t         oq[$];
    time           dq[$];
    bit            m_open;
    bit            m_len_err;
    logic [CW-1:0] m_cnt;
`ifdef PACKER_ARB_HEADER_EN
    bit            m_hdr_done;
`endif
    int            n_vec = 0;
    int            n_err = 0;
    item_t         m_it;
    bit            m_exp_v, m_exp_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_hdr_ready();
`ifdef PACKER_ARB_HEADER_EN
        return !m_hdr_done;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_enc_ready();
`ifdef PACKER_ARB_HEADER_EN
        return m_hdr_done;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_accept(input bit is_hdr, input logic [W-1:0] d, input logic [4:0] n,
                                input bit l);
        int    len;
        item_t it;
        len = (int'(n) > W) ? W : int'(n);
        if (int'(n) > W) m_len_err = 1'b1;
        if (len > 0) begin
            it.d   = W'(int'(d) % (1 << len));
            it.n   = 5'(len);
            it.l   = !is_hdr && l;
            it.due = $time + 5;
            oq.push_back(it);
        end
        m_open = 1'b1;
        if (is_hdr) begin
`ifdef PACKER_ARB_HEADER_EN
            if (l) m_hdr_done = 1'b1;
`endif
        end else if (l) begin
            m_open = 1'b0;
`ifdef PACKER_ARB_HEADER_EN
            m_hdr_done = 1'b0;
`endif
            m_cnt = m_cnt + 1'b1;
            dq.push_back($time + 5);
        end
    endtask

    task automatic step(input bit hv, input logic [W-1:0] hd, input logic [4:0] hn, input bit hl,
                        input bit ev, input logic [W-1:0] ed, input logic [4:0] en, input bit el);
        bit hr, er;
        hdr_valid = hv; hdr_data = hd; hdr_num_bits = hn; hdr_last = hl;
        enc_valid = ev; enc_data = ed; enc_num_bits = en; enc_last = el;
        hr = m_hdr_ready();
        er = m_enc_ready();
        @(posedge clk);
        if (hv && hr) model_accept(1'b1, hd, hn, hl);
        else if (ev && er) model_accept(1'b0, ed, en, el);
        #1;
        hdr_valid = 1'b0;
        enc_valid = 1'b0;
    endtask

    task automatic do_reset();
        hdr_valid = 1'b0;
        enc_valid = 1'b0;
        areset    = 1'b1;
        @(posedge clk);
        oq.delete();
        dq.delete();
        m_open    = 1'b0;
        m_len_err = 1'b0;
        m_cnt     = '0;
`ifdef PACKER_ARB_HEADER_EN
        m_hdr_done = 1'b0;
`endif
        #1 areset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_num_bits", out_num_bits, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
    endtask

    task automatic open_frame();
`ifdef PACKER_ARB_HEADER_EN
        step(1'b1, 8'h01, 5'd1, 1'b1, 1'b0, '0, '0, 1'b0);
`endif
    endtask

    function automatic logic [4:0] rand_nb();
        int r = $urandom_range(0, 9);
        if (r == 0) return 5'd0;
        if (r == 1) return 5'($urandom_range(9, 31));
        return 5'($urandom_range(1, W));
    endfunction

    always @(negedge clk) begin
        while (oq.size() != 0 && oq[0].due < $time) begin
            n_vec++; n_err++;
            $display("FAIL out_missing: no codeword at %0t, expected data %0h bits %0d",
                     oq[0].due, oq[0].d, oq[0].n);
            void'(oq.pop_front());
        end
        while (dq.size() != 0 && dq[0] < $time) begin
            n_vec++; n_err++;
            $display("FAIL done_missing: no done pulse at %0t, expected 1", dq[0]);
            void'(dq.pop_front());
        end
        m_exp_v = (oq.size() != 0) && (oq[0].due == $time);
        chk("out_valid", out_valid, m_exp_v);
        if (m_exp_v) begin
            m_it = oq.pop_front();
            chk("out_data", out_data, m_it.d);
            chk("out_num_bits", out_num_bits, m_it.n);
            chk("out_last", out_last, m_it.l);
        end else begin
            chk("out_last_idle", out_last, 0);
        end
        m_exp_d = (dq.size() != 0) && (dq[0] == $time);
        chk("done", done, m_exp_d);
        if (m_exp_d) void'(dq.pop_front());
        chk("frame_count", frame_count, m_cnt);
        chk("busy", busy, m_open);
        chk("hdr_ready", hdr_ready, m_hdr_ready());
        chk("enc_ready", enc_ready, m_enc_ready());
        chk("len_err", len_err, m_len_err);
    end

    initial begin
        areset = 1'b1;
        {hdr_valid, hdr_last, enc_valid, enc_last} = '0;
        hdr_data = '0; hdr_num_bits = '0; enc_data = '0; enc_num_bits = '0;
        do_reset();

`ifdef PACKER_ARB_HEADER_EN
        // Header then body frame; encoder held valid while headers are pending.
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h33, 5'd6, 1'b0);
        chk("enc_blocked_ready", enc_ready, 0);
        chk("enc_blocked_valid", out_valid, 0);
        step(1'b1, 8'h2D, 5'd6, 1'b0, 1'b1, 8'h33, 5'd6, 1'b0);
        chk("hdr0_data", out_data, 8'h2D);
        chk("hdr0_bits", out_num_bits, 6);
        chk("hdr0_enc_ready", enc_ready, 0);
        step(1'b1, 8'h05, 5'd3, 1'b1, 1'b1, 8'h33, 5'd6, 1'b0);
        chk("hdr1_data", out_data, 8'h05);
        chk("hdr1_last", out_last, 0);
        chk("hdr1_enc_ready", enc_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hEE, 5'd2, 1'b1, 1'b1, 8'h33, 5'd6, i == 3);
            chk("body_data", out_data, 8'h33);
            chk("body_last", out_last, i == 3);
        end
        chk("frame_done", done, 1);
        chk("frame_count_1", frame_count, 1);
        do_reset();
`endif

        // Masking, clamping and sticky length error.
        open_frame();
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'hFF, 5'd3, 1'b0);
        chk("mask_data", out_data, 8'h07);
        chk("mask_len_err", len_err, 0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'hAB, 5'd12, 1'b0);
        chk("clamp_bits", out_num_bits, 8);
        chk("clamp_data", out_data, 8'hAB);
        chk("len_err_set", len_err, 1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h12, 5'd4, 1'b1);
        chk("sticky_len_err", len_err, 1);
        chk("last_data", out_data, 8'h02);
        chk("last_flag", out_last, 1);
        chk("last_done", done, 1);

        // Zero-length codeword carrying the frame end.
        open_frame();
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h5A, 5'd0, 1'b1);
        chk("zero_valid", out_valid, 0);
        chk("zero_last", out_last, 0);
        chk("zero_done", done, 1);
        chk("zero_count", frame_count, 2);
        chk("zero_busy", busy, 0);

        // Reset in the middle of a frame abandons it.
        do_reset();
        open_frame();
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h11, 5'd5, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h22, 5'd6, 1'b0);
        chk("midrst_busy_pre", busy, 1);
        do_reset();
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("midrst_done", done, 0);
        chk("midrst_count", frame_count, 0);
        open_frame();
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h3C, 5'd8, 1'b1);
        chk("after_rst_last", out_last, 1);
        chk("after_rst_count", frame_count, 1);

        // Randomised traffic on both sources with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step($urandom_range(0, 1) == 1, W'($urandom), rand_nb(), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, W'($urandom), rand_nb(), $urandom_range(0, 3) == 0);
        end

`ifndef PACKER_ARB_HEADER_EN
        // Counter wrap with header traffic that must be ignored throughout.
        do_reset();
        repeat (32'hFFFF) step(1'b1, 8'hC3, 5'd4, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1);
        chk("wrap_pre", frame_count, 16'hFFFF);
        step(1'b1, 8'hC3, 5'd4, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1);
        chk("wrap_zero", frame_count, 16'h0000);
        chk("wrap_hdr_ready", hdr_ready, 0);
`endif

        @(negedge clk);
        #1;
        chk("drain_out", oq.size(), 0);
        chk("drain_done", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/packer_arbiter.md
PACKER_ARBITER -- requirements
Module: packer_arbiter

Interface
REQ-001 Parameter MAX_IN_WIDTH, default 8, SHALL set the codeword data width on all data ports.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the frame_count width.
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 areset  in  1  synchronous, active-high reset.
REQ-005 hdr_valid / hdr_ready  in / out  1 / 1  header source handshake.
REQ-006 hdr_data / hdr_num_bits / hdr_last  in  MAX_IN_WIDTH / 5 / 1  header codeword, its length, last header codeword.
REQ-007 enc_valid / enc_ready  in / out  1 / 1  encoder source handshake.
REQ-008 enc_data / enc_num_bits / enc_last  in  MAX_IN_WIDTH / 5 / 1  encoder codeword, its length, last codeword of frame.
REQ-009 out_valid / out_last / out_data / out_num_bits  out  1 / 1 / MAX_IN_WIDTH / 5  codeword stream to packer; no backpressure.
REQ-010 busy  out  1  high when state is not IDLE.
REQ-011 done  out  1  one-cycle pulse per completed frame.
REQ-012 frame_count  out  CNT_WIDTH  number of completed frames.
REQ-013 len_err  out  1  sticky over-length flag.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, HEADER, BODY.
REQ-015 hdr_ready SHALL be 1 in IDLE and HEADER and 0 in BODY; enc_ready SHALL be 1 only in BODY; both SHALL be decoded from registered state only.
REQ-016 Accept = valid AND ready on the same rising edge.
REQ-017 A header accept without hdr_last in IDLE or HEADER SHALL move to HEADER; a header accept with hdr_last SHALL move to BODY.
REQ-018 An encoder accept with enc_last in BODY SHALL move to IDLE; any other encoder accept SHALL stay in BODY.
REQ-019 Each accepted codeword SHALL appear on out_* exactly one cycle after acceptance, all outputs registered.
REQ-020 out_last SHALL be 1 only for the forwarded enc_last codeword; hdr_last SHALL never reach out_last.
REQ-021 out_data bits at positions >= out_num_bits SHALL be driven 0.
REQ-022 An accepted codeword with num_bits = 0 SHALL be consumed with out_valid = 0 the next cycle, but SHALL still perform its state transition; if it carries enc_last, done SHALL still pulse and frame_count SHALL still increment, while out_last stays 0.
REQ-023 An accepted codeword with num_bits > MAX_IN_WIDTH SHALL be forwarded with out_num_bits = MAX_IN_WIDTH and SHALL set len_err; len_err SHALL clear only on reset.
REQ-024 out_valid SHALL be 0 in every cycle not following an accept.
REQ-025 done SHALL pulse, and frame_count SHALL increment, in the same cycle that out_last is driven, i.e. one cycle after the enc_last accept.
REQ-026 frame_count SHALL wrap from all-ones to 0 without any flag.
REQ-027 Source valid asserted while that source's ready is 0 SHALL be ignored and SHALL NOT alter state or outputs.

Reset
REQ-028 While areset = 1 at a rising edge: state SHALL go to IDLE; out_valid, out_last, done, busy, and len_err SHALL go to 0; out_data, out_num_bits, and frame_count SHALL go to 0.
REQ-029 Reset mid-frame SHALL abandon the frame: no out_last, no done, and no count change.
REQ-030 The first accept SHALL be possible on the first edge after areset deasserts.

Configuration
REQ-031 With macro PACKER_ARB_HEADER_EN defined, the HEADER path SHALL operate as specified above.
REQ-032 Without PACKER_ARB_HEADER_EN: HEADER state and header logic SHALL be absent; hdr_ready SHALL be tied to 0; IDLE SHALL assert enc_ready and treat an encoder accept exactly as in BODY (enc_last returns to IDLE; otherwise go to BODY).

Verification
REQ-033 PACKER_ARB_HEADER_EN defined; headers 0x2D/6 then 0x05/3 with last, then encoder 0x33/6 x4 with last on the 4th -> out sequence 0x2D/6, 0x05/3, 0x33/6 x4; out_last only on the 4th 0x33; one done pulse; frame_count = 1.
REQ-034 enc_valid = 1 held from reset while in IDLE with header pending -> enc_ready stays 0 until hdr_last is accepted; no encoder codeword is forwarded early.
REQ-035 Encoder codeword 0xFF with num_bits = 3 -> out_data = 0x07 and len_err = 0; codeword with num_bits = 12 -> out_num_bits = 8, len_err = 1 and sticky.
REQ-036 num_bits = 0 with enc_last -> out_valid stays 0, done pulses, frame_count increments, state returns to IDLE.
REQ-037 areset pulsed after 2 body codewords -> busy = 0, no out_last, frame_count unchanged; next frame completes normally.
REQ-038 PACKER_ARB_HEADER_EN undefined, 0xFFFF frames completed with CNT_WIDTH = 16, then one more -> hdr_ready is always 0, and frame_count wraps to 0x0000.
